// File: rtl/hint_solver_pkg.sv
// -----------------------------------------------------------------------------
// hint_solver_pkg
// Shared types and constants for the AND/OR hint game solver.
//   solver_state_t : FSM state encoding for hint_solver
//   ATT_W / ATT_MAX: attempt counter width and saturation value
//   W_DEFAULT      : default password / guess / hint width
// -----------------------------------------------------------------------------
package hint_solver_pkg;

    localparam int ATT_W     = 8;
    localparam int ATT_MAX   = 255;
    localparam int W_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        PROBE_REQ,
        PROBE_WAIT,
        CONFIRM_REQ,
        CONFIRM_WAIT,
        DONE
    } solver_state_t;

endpackage : hint_solver_pkg

// File: rtl/hint_solver_timer.sv
// -----------------------------------------------------------------------------
// hint_solver_timer
// Wait-state watchdog. Counts cycles while enabled; expired_o is high on the
// cycle that is the LIMIT-th counted cycle since the last clear, so the owner
// can abort on that same edge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (wins over en_i)
//   en_i       : count this cycle
//   expired_o  : current cycle completes LIMIT waiting cycles
// -----------------------------------------------------------------------------
module hint_solver_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // The count holds cycles already waited; the current waiting cycle is
    // the (count_q+1)-th, hence the compare against LIMIT-1.
    assign expired_o = (count_q == CNT_W'(LIMIT - 1));

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : hint_solver_timer

// File: rtl/hint_solver.sv
// -----------------------------------------------------------------------------
// hint_solver
// Initiator side of the AND/OR hint game. Probes the hint checker, deduces the
// stored W-bit password from the returned hints, then submits the deduced value
// as a confirming guess and reports the outcome.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   go                      : start a solve (accepted only in IDLE or DONE)
//   guess_valid/guess       : guess offered to the checker
//   guess_ready             : checker accepts when guess_valid & guess_ready
//   hint_valid              : and_hint/or_hint valid this cycle
//   and_hint/or_hint        : password & guess, password | guess
//   busy                    : solve in progress
//   done                    : level, high in DONE until next go or reset
//   success/error           : confirm outcome (error also on timeout)
//   found                   : deduced password
//   attempts                : accepted guesses this solve, saturating
//
// Build option HINT_SOLVER_SHORTCUT_EN: when defined the probe phase is one
// all-zero guess whose or_hint is the password itself (2 attempts total);
// otherwise W one-hot probes recover one bit each (W+1 attempts total).
// -----------------------------------------------------------------------------
module hint_solver
    import hint_solver_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic             guess_valid,
    output logic [W-1:0]     guess,
    input  logic             guess_ready,
    input  logic             hint_valid,
    input  logic [W-1:0]     and_hint,
    input  logic [W-1:0]     or_hint,
    output logic             busy,
    output logic             done,
    output logic             success,
    output logic             error,
    output logic [W-1:0]     found,
    output logic [ATT_W-1:0] attempts
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

    solver_state_t    state_q,    state_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [W-1:0]     found_q,    found_d;
    logic [ATT_W-1:0] attempts_q, attempts_d;
    logic             done_q,     done_d;
    logic             success_q,  success_d;
    logic             error_q,    error_d;

    logic             timer_clr;
    logic             timer_en;
    logic             timer_expired;
    logic [ATT_W-1:0] attempts_inc;

    hint_solver_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    assign attempts_inc = (attempts_q == ATT_W'(ATT_MAX)) ? attempts_q
                                                          : attempts_q + 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        idx_d       = idx_q;
        found_d     = found_q;
        attempts_d  = attempts_q;
        done_d      = done_q;
        success_d   = success_q;
        error_d     = error_q;
        timer_clr   = 1'b0;
        timer_en    = 1'b0;
        guess_valid = 1'b0;
        guess       = '0;

        unique case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d    = PROBE_REQ;
                    idx_d      = '0;
                    found_d    = '0;
                    attempts_d = '0;
                    done_d     = 1'b0;
                    success_d  = 1'b0;
                    error_d    = 1'b0;
                    timer_clr  = 1'b1;
                end
            end

            PROBE_REQ: begin
                guess_valid = 1'b1;
`ifdef HINT_SOLVER_SHORTCUT_EN
                guess       = '0;
`else
                guess       = W'(1) << idx_q;
`endif
                if (guess_ready) begin
                    attempts_d = attempts_inc;
                    state_d    = PROBE_WAIT;
                    timer_clr  = 1'b1;
                end
            end

            PROBE_WAIT: begin
                if (hint_valid) begin
`ifdef HINT_SOLVER_SHORTCUT_EN
                    // password | 0 is the password itself.
                    found_d = or_hint;
                    state_d = CONFIRM_REQ;
`else
                    // A one-hot probe exposes exactly one password bit.
                    found_d[idx_q] = and_hint[idx_q];
                    if (idx_q == IDX_LAST) begin
                        state_d = CONFIRM_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = PROBE_REQ;
                    end
`endif
                end else if (timer_expired) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    success_d = 1'b0;
                end else begin
                    timer_en = 1'b1;
                end
            end

            CONFIRM_REQ: begin
                guess_valid = 1'b1;
                guess       = found_q;
                if (guess_ready) begin
                    attempts_d = attempts_inc;
                    state_d    = CONFIRM_WAIT;
                    timer_clr  = 1'b1;
                end
            end

            CONFIRM_WAIT: begin
                if (hint_valid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    // Both hints equal the guess only when guess == password.
                    if ((and_hint == found_q) && (or_hint == found_q)) begin
                        success_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (timer_expired) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    success_d = 1'b0;
                end else begin
                    timer_en = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            found_q    <= '0;
            attempts_q <= '0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            found_q    <= found_d;
            attempts_q <= attempts_d;
            done_q     <= done_d;
            success_q  <= success_d;
            error_q    <= error_d;
        end
    end

    // guess_valid/guess decode straight from state_q, so they drop the moment
    // reset forces the state register back to IDLE.
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = done_q;
    assign success  = success_q;
    assign error    = error_q;
    assign found    = found_q;
    assign attempts = attempts_q;

endmodule : hint_solver

// File: tb/tb_hint_solver.sv
// -----------------------------------------------------------------------------
// tb_hint_solver
// Self-checking bench for hint_solver (W=6, TIMEOUT=16). A checker model
// answers every accepted guess with AND/OR hints against its password; the
// expected guess sequence and outcome are derived from the game rules.
// Honours HINT_SOLVER_SHORTCUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hint_solver;

    localparam int W       = 6;
    localparam int TIMEOUT = 16;
`ifdef HINT_SOLVER_SHORTCUT_EN
    localparam int N_ATT = 2;
`else
    localparam int N_ATT = W + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         go;
    logic         guess_valid;
    logic [W-1:0] guess;
    logic         guess_ready;
    logic         hint_valid;
    logic [W-1:0] and_hint;
    logic [W-1:0] or_hint;
    logic         busy;
    logic         done;
    logic         success;
    logic         error;
    logic [W-1:0] found;
    logic [7:0]   attempts;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] guesses[$];

    typedef struct {
        logic [W-1:0] pwd0;        // password at start
        bit           chg;         // swap password when confirm is accepted
        logic [W-1:0] pwd1;        // password after swap
        bit           exp_success;
        logic [W-1:0] exp_found;
    } vec_t;

    vec_t tbl[5];

    hint_solver #(
        .W      (W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .guess_valid(guess_valid),
        .guess      (guess),
        .guess_ready(guess_ready),
        .hint_valid (hint_valid),
        .and_hint   (and_hint),
        .or_hint    (or_hint),
        .busy       (busy),
        .done       (done),
        .success    (success),
        .error      (error),
        .found      (found),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Play one full game. The checker accepts guesses with probability
    // ready_pct% and answers each one 1..max_dly cycles after acceptance.
    task automatic run_solve(input logic [W-1:0] p0, input bit chg, input logic [W-1:0] p1,
                             input int ready_pct, input int max_dly);
        logic [W-1:0] cur;
        logic [W-1:0] pend;
        bit           pend_v;
        int           cnt;
        int           budget;
        guesses.delete();
        cur    = p0;
        pend   = '0;
        pend_v = 1'b0;
        cnt    = 0;
        @(negedge clk);
        go = 1'b1;
        hint_valid = 1'b0;
        guess_ready = 1'b0;
        @(negedge clk);
        go = 1'b0;
        budget = 0;
        while (!done && budget < 600) begin
            hint_valid = 1'b0;
            if (pend_v) begin
                if (cnt == 0) begin
                    hint_valid = 1'b1;
                    and_hint   = cur & pend;
                    or_hint    = cur | pend;
                    pend_v     = 1'b0;
                end else begin
                    cnt--;
                end
            end
            guess_ready = ($urandom_range(99) < ready_pct);
            if (guess_valid && guess_ready) begin
                guesses.push_back(guess);
                pend   = guess;
                pend_v = 1'b1;
                cnt    = $urandom_range(max_dly - 1);
                if (chg && guesses.size() == N_ATT) cur = p1;
            end
            @(negedge clk);
            budget++;
        end
        hint_valid  = 1'b0;
        guess_ready = 1'b0;
        check("solve_reached_done", done, 1);
    endtask

    // Reference: one-hot probes reveal one bit each (or one all-zero probe
    // reveals everything); the confirm guess is the original password.
    task automatic verify(input string tag, input logic [W-1:0] p0, input logic [W-1:0] pfin,
                          input bit exp_succ, input logic [W-1:0] exp_found);
        logic [W-1:0] exp_q[$];
        exp_q.delete();
`ifdef HINT_SOLVER_SHORTCUT_EN
        exp_q.push_back('0);
`else
        for (int i = 0; i < W; i++) exp_q.push_back(W'(1 << i));
`endif
        exp_q.push_back(p0);
        check({tag, "_nguess"}, guesses.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < guesses.size(); i++)
            check($sformatf("%s_guess%0d", tag, i), guesses[i], exp_q[i]);
        check({tag, "_success"}, success, exp_succ);
        check({tag, "_error"}, error, !exp_succ);
        check({tag, "_found"}, found, exp_found);
        check({tag, "_attempts"}, attempts, N_ATT);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_model"}, exp_succ, (pfin == p0));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] g0;
        logic [W-1:0] g1;
        logic [W-1:0] p0;
        logic [W-1:0] p1;
        bit           chg;
        int           waits;

        rst_n = 1'b0;
        go = 1'b0;
        guess_ready = 1'b0;
        hint_valid = 1'b0;
        and_hint = '0;
        or_hint = '0;
`ifdef HINT_SOLVER_SHORTCUT_EN
        g0 = '0;
        g1 = 6'b101101;
`else
        g0 = 6'b000001;
        g1 = 6'b000010;
`endif

        // Reset state
        #12;
        check("rst_guess_valid", guess_valid, 0);
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_success", success, 0);
        check("rst_error", error, 0);
        check("rst_found", found, 0);
        check("rst_attempts", attempts, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // hint_valid in IDLE must be ignored
        hint_valid = 1'b1;
        and_hint = '1;
        or_hint = '1;
        @(negedge clk);
        hint_valid = 1'b0;
        check("idle_hint_ignored_busy", busy, 0);
        check("idle_hint_ignored_found", found, 0);

        // Directed table: back-to-back checker, hint one cycle after accept
        tbl[0] = '{6'b101101, 1'b0, 6'b101101, 1'b1, 6'b101101};
        tbl[1] = '{6'b000000, 1'b0, 6'b000000, 1'b1, 6'b000000};
        tbl[2] = '{6'b111111, 1'b0, 6'b111111, 1'b1, 6'b111111};
        tbl[3] = '{6'b101101, 1'b1, 6'b000111, 1'b0, 6'b101101};
        tbl[4] = '{6'b000001, 1'b1, 6'b100001, 1'b0, 6'b000001};
        for (int i = 0; i < 5; i++) begin
            run_solve(tbl[i].pwd0, tbl[i].chg, tbl[i].pwd1, 100, 1);
            verify($sformatf("tbl%0d", i), tbl[i].pwd0,
                   tbl[i].chg ? tbl[i].pwd1 : tbl[i].pwd0,
                   tbl[i].exp_success, tbl[i].exp_found);
        end

        // Randomised games with stalls and variable hint latency
        for (int i = 0; i < 20; i++) begin
            p0  = W'($urandom);
            p1  = W'($urandom);
            chg = ($urandom_range(3) == 0);
            run_solve(p0, chg, p1, $urandom_range(100, 30), $urandom_range(6, 1));
            verify($sformatf("rnd%0d", i), p0, chg ? p1 : p0,
                   chg ? (p1 == p0) : 1'b1, p0);
        end

        // Stall in PROBE_REQ (with stray hints), then no hint -> timeout
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        guess_ready = 1'b0;
        hint_valid = 1'b1;
        and_hint = '1;
        or_hint = '1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), guess_valid, 1);
            check($sformatf("stall%0d_guess", i), guess, g0);
            check($sformatf("stall%0d_attempts", i), attempts, 0);
            @(negedge clk);
        end
        hint_valid = 1'b0;
        and_hint = '0;
        or_hint = '0;
        guess_ready = 1'b1;
        @(negedge clk);
        guess_ready = 1'b0;
        check("accept_attempts", attempts, 1);
        check("accept_valid_low", guess_valid, 0);
        waits = 0;
        while (!done && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        check("timeout_cycles", waits, TIMEOUT);
        check("timeout_done", done, 1);
        check("timeout_error", error, 1);
        check("timeout_success", success, 0);
        check("timeout_attempts", attempts, 1);
        check("timeout_found", found, 0);

        // go while busy is ignored; the solve carries on from where it was
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        guess_ready = 1'b1;
        @(negedge clk);
        guess_ready = 1'b0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("busy_go_busy", busy, 1);
        check("busy_go_wait", guess_valid, 0);
        check("busy_go_attempts", attempts, 1);
        hint_valid = 1'b1;
        and_hint = 6'b101101 & g0;
        or_hint = 6'b101101 | g0;
        @(negedge clk);
        hint_valid = 1'b0;
        check("busy_go_next_valid", guess_valid, 1);
        check("busy_go_next_guess", guess, g1);
        check("busy_go_attempts2", attempts, 1);

        // Reset mid-solve (in PROBE_WAIT): outputs clear without a clock edge
        apply_reset();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        guess_ready = 1'b1;
        @(negedge clk);
        guess_ready = 1'b0;
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_guess_valid", guess_valid, 0);
        check("mid_rst_attempts", attempts, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_hint_solver
